// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the frame-buffer arbiter and the VGA driver:
//   - default frame-buffer address/pixel widths
//   - 640x480@60 timing constants (pixel clock ~25.175 MHz)
//   - arbiter state encoding
//   - helper to size the contested-display run counter
// ---------------------------------------------------------------------------
package vga_pkg;

   // Frame buffer geometry: 640x480 words of 8:8:8 RGB.
   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 24;

   // Horizontal timing, in pixel clocks.
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   // Vertical timing, in lines.
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int FB_PIXELS = H_VISIBLE * V_VISIBLE;

   // S_DISP_PRI : display wins contention until its run limit is reached.
   // S_FORCE_WR : one cycle in which the writer is guaranteed the port.
   typedef enum logic [0:0] {
      S_DISP_PRI = 1'b0,
      S_FORCE_WR = 1'b1
   } arb_state_t;

   // Width of a counter holding 0..max_run. A zero run limit still needs a
   // 1-bit register so the design elaborates.
   function automatic int run_cnt_w(input int max_run);
      if (max_run < 1) return 1;
      return $clog2(max_run + 1);
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter_if
// Bundle of every bus the frame-buffer arbiter touches:
//   display read port  : disp_req/disp_addr -> disp_gnt, disp_rvalid/disp_rdata
//   writer port        : wr_valid/wr_addr/wr_data -> wr_ready
//   single-port RAM    : mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata
//   status             : disp_stall_cnt
// Modports:
//   slave  - the arbiter
//   master - the clients plus the RAM (testbench / integration side)
// ---------------------------------------------------------------------------
interface vga_fb_arbiter_if
   import vga_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
);

   // display read port
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic              disp_rvalid;
   logic [DATA_W-1:0] disp_rdata;

   // writer port
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   // RAM port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // status
   logic [15:0]       disp_stall_cnt;

   modport slave (
      input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
      output disp_gnt, disp_rvalid, disp_rdata, wr_ready,
      output mem_en, mem_we, mem_addr, mem_wdata, disp_stall_cnt
   );

   modport master (
      output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
      input  disp_gnt, disp_rvalid, disp_rdata, wr_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata, disp_stall_cnt
   );

endinterface

// File: rtl/fb_rd_return_pipe.sv
// ---------------------------------------------------------------------------
// fb_rd_return_pipe
// Two-stage return path for display reads. A read issued to the RAM in
// cycle t+1 has its data on mem_rdata in t+2; that data is registered and
// presented with rvalid in t+3. One entry per cycle, so back-to-back reads
// come back back-to-back and in issue order.
// Ports:
//   clk, rst    clock, async active-low reset (flushes in-flight reads)
//   issue_rd    a read is on the RAM port this cycle
//   mem_rdata   RAM read data (valid the cycle after issue)
//   rvalid      rdata holds a returned pixel this cycle
//   rdata       returned pixel
// ---------------------------------------------------------------------------
module fb_rd_return_pipe #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   localparam int STAGES = 2;

   // vld_pipe[1]: RAM data on mem_rdata now; vld_pipe[STAGES]: rdata valid.
   logic [STAGES:1] vld_pipe;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         rdata    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], issue_rd};
         if (vld_pipe[STAGES-1])
            rdata <= mem_rdata;
      end
   end

   assign rvalid = vld_pipe[STAGES];

endmodule

// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port frame-buffer RAM between the VGA display reader and
// the image-processing writer.
//
// Arbitration: the display normally wins contention so the scan-out never
// starves, but after MAX_DISP_RUN consecutive contested display grants the
// writer is handed the port and the FSM spends one cycle in S_FORCE_WR,
// where the writer (if still requesting) wins again before display priority
// resumes. Grants are combinational; the RAM access is issued one cycle
// after the handshake from registered address/data.
//
// Ports:
//   clk   clock
//   rst   asynchronous assert, active low; release must be synchronised to
//         clk upstream
//   bus   vga_fb_arbiter_if.slave: display port, writer port, RAM port and
//         disp_stall_cnt (saturating count of denied display cycles)
// ---------------------------------------------------------------------------
module vga_fb_arbiter
   import vga_pkg::*;
#(
   parameter int ADDR_W       = FB_ADDR_W,
   parameter int DATA_W       = FB_DATA_W,
   parameter int MAX_DISP_RUN = 8
) (
   input  logic            clk,
   input  logic            rst,
   vga_fb_arbiter_if.slave bus
);

   localparam int                RUN_W   = run_cnt_w(MAX_DISP_RUN);
   localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_DISP_RUN);

   arb_state_t        state;
   logic [RUN_W-1:0]  run_cnt;
   logic              contested;
   logic              gnt_d;
   logic              gnt_w;
   logic [ADDR_W-1:0] issue_addr;

   assign contested = bus.disp_req & bus.wr_valid;

   // ------------------------------------------------------------------
   // Grant decode. Both grants are held low while in reset so nothing is
   // accepted that the flushed pipeline would lose.
   // ------------------------------------------------------------------
   always_comb begin
      gnt_d = 1'b0;
      gnt_w = 1'b0;
      if (rst) begin
         if (state == S_FORCE_WR) begin
            gnt_w = bus.wr_valid;
            gnt_d = bus.disp_req & ~bus.wr_valid;
         end else if (contested) begin
            if (run_cnt < RUN_MAX) gnt_d = 1'b1;
            else                   gnt_w = 1'b1;
         end else begin
            gnt_d = bus.disp_req;
            gnt_w = bus.wr_valid;
         end
      end
   end

   assign bus.disp_gnt = gnt_d;
   assign bus.wr_ready = gnt_w;

   // ------------------------------------------------------------------
   // Arbitration FSM. run_cnt counts contested display grants only; an
   // uncontested display grant leaves it alone, an uncontested write
   // clears it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_DISP_PRI;
         run_cnt <= '0;
      end else begin
         case (state)
            S_FORCE_WR: begin
               state   <= S_DISP_PRI;
               run_cnt <= '0;
            end
            default: begin
               if (contested) begin
                  if (run_cnt < RUN_MAX) begin
                     run_cnt <= run_cnt + 1'b1;
                  end else begin
                     state   <= S_FORCE_WR;
                     run_cnt <= '0;
                  end
               end else if (bus.wr_valid) begin
                  run_cnt <= '0;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // RAM issue stage: one cycle after the handshake.
   // ------------------------------------------------------------------
   assign issue_addr = gnt_w ? bus.wr_addr : bus.disp_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.mem_en <= gnt_d | gnt_w;
         bus.mem_we <= gnt_w;
         if (gnt_d | gnt_w)
            bus.mem_addr <= issue_addr;
         if (gnt_w)
            bus.mem_wdata <= bus.wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Display stall statistic, saturating.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         bus.disp_stall_cnt <= '0;
      else if (bus.disp_req && !gnt_d && (bus.disp_stall_cnt != 16'hFFFF))
         bus.disp_stall_cnt <= bus.disp_stall_cnt + 16'd1;
   end

   // ------------------------------------------------------------------
   // Read return path
   // ------------------------------------------------------------------
   fb_rd_return_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_ret (
      .clk       (clk),
      .rst       (rst),
      .issue_rd  (bus.mem_en & ~bus.mem_we),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.disp_rvalid),
      .rdata     (bus.disp_rdata)
   );

endmodule
